// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module : div_pkg
// Brief  : Shared types and sizing helpers for the sequential divider.
// Rev    : 1.0
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Counter must hold values 0..WIDTH
    function automatic int div_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division iteration (shift, trial subtract, select).
// Rev    : 1.0
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dq,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dq
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_low;
    logic           w_no_borrow;

    assign w_shift = {i_rem, i_dq[WIDTH-1]};

    // WIDTH+1-bit A + ~B + 1 split at bit WIDTH; the divisor's top bit is 0,
    // so the final carry is the shifted MSB ORed with the low-part carry.
    assign w_low       = {1'b0, w_shift[WIDTH-1:0]} + {1'b0, ~i_dvs} + {{WIDTH{1'b0}}, 1'b1};
    assign w_no_borrow = w_shift[WIDTH] | w_low[WIDTH];

    assign o_rem = w_no_borrow ? w_low[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_dq  = {i_dq[WIDTH-2:0], w_no_borrow};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module : seq_divider
// Brief  : Multi-cycle restoring UDIV/SDIV divider, one quotient bit per clock.
// Rev    : 1.0
// ============================================================================
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = div_cnt_width(WIDTH);

    div_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remd;
    logic             r_dbz;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_dq_nxt;
    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic             w_dvs_zero;

    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_abs_dvd  = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_abs_dvs  = w_dvs_neg ? (~divisor + 1'b1) : divisor;
    assign w_dvs_zero = (divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_dq  (r_dq),
        .i_dvs (r_dvs),
        .o_rem (w_rem_nxt),
        .o_dq  (w_dq_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dq    <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_remd  <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DIV_RUN: begin
                    if (r_dz) begin
                        // r_dq carries the raw dividend when dividing by zero
                        r_quot  <= '0;
                        r_remd  <= r_dq;
                        r_dbz   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DIV_DONE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dq  <= w_dq_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_quot  <= r_neg_q ? (~w_dq_nxt + 1'b1) : w_dq_nxt;
                            r_remd  <= r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
                            r_dbz   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DIV_DONE;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_dq    <= w_dvs_zero ? dividend : w_abs_dvd;
                        r_dvs   <= w_abs_dvs;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                        r_dz    <= w_dvs_zero;
                        r_busy  <= 1'b1;
                        r_state <= DIV_RUN;
                    end else begin
                        r_state <= DIV_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remd;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module : tb_seq_divider
// Brief  : Self-checking bench: directed vector table, corner sequences, random vs model.
// Rev    : 1.0
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb, sq, sr;
        if (b == '0) begin
            q = '0; r = a; dz = 1'b1;
        end else if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            sq = sa / sb;
            sr = sa - sq * sb;
            q = sq[W-1:0]; r = sr[W-1:0]; dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Called #1 after a clock edge; start is driven immediately so a call
    // right after done lands its start in the DONE cycle.
    task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject, output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        logic [W-1:0] q_prev, r_prev;
        bit           held, overlap;
        q_prev = quotient; r_prev = remainder;
        held = 1'b1; overlap = 1'b0;
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        lat = 0;
        while (lat < 100) begin
            if (inject && lat == 5) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy && done) overlap = 1'b1;
            if (done) break;
            if (quotient !== q_prev || remainder !== r_prev) held = 1'b0;
        end
        start = 1'b0;
        if (lat >= 100) begin
            checks++; errors++;
            $display("FAIL timeout: no done within 100 cycles");
        end
        chk("results_held_during_run", {63'd0, held}, 64'd1);
        chk("busy_done_exclusive", {63'd0, overlap}, 64'd0);
        q = quotient; r = remainder; dz = div_by_zero;
    endtask

    task automatic run_and_check(input string tag, input logic sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit inject,
                                 input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        logic [W-1:0] q, r;
        logic         dz;
        int           lat;
        do_op(sgn, a, b, inject, q, r, dz, lat);
        chk({tag, "_quot"}, {32'd0, q}, {32'd0, eq});
        chk({tag, "_rem"},  {32'd0, r}, {32'd0, er});
        chk({tag, "_dbz"},  {63'd0, dz}, {63'd0, edz});
        chk({tag, "_latency"}, 64'(lat), (b == '0) ? 64'd1 : 64'd32);
    endtask

    initial begin
        logic [W-1:0] mq, mr, a, b;
        logic         mdz, sgn;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_quot", {32'd0, quotient}, 64'd0);
        chk("reset_rem",  {32'd0, remainder}, 64'd0);
        chk("reset_dbz",  {63'd0, div_by_zero}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        tbl[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
        tbl[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        tbl[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
        tbl[5] = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd5,          1'b1};
        tbl[6] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
        tbl[7] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd5,          1'b1};

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, 1'b0,
                          tbl[i].q, tbl[i].r, tbl[i].dz);
        end
        // After the signed 5/0, 9/3 must clear the flag
        run_and_check("clear_dbz", 1'b0, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        @(posedge clk); #1;
        chk("done_single_pulse", {63'd0, done}, 64'd0);

        run_and_check("ignore_start_mid_run", 1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);

        // Abort mid-RUN: reset coincides with step 10
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_quot", {32'd0, quotient}, 64'd0);
        chk("abort_rem",  {32'd0, remainder}, 64'd0);
        run_and_check("after_abort", 1'b0, 32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            model(sgn, a, b, mq, mr, mdz);
            run_and_check("rand", sgn, a, b, 1'b0, mq, mr, mdz);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk("rand_done_pulse", {63'd0, done}, 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
